toggle_handshake_sender: RTL and testbench

- Source-side transmitter of the toggle-flag CDC protocol, running entirely in the sending clock domain.
- Accepts bytes (MIDI-width by default) on a valid/ready interface and presents each byte on a held-stable `xfer_data` bus.
- Announces each transfer by flipping `req_toggle`, then waits for the far domain to return `ack_toggle` equal to `req_toggle`.
- A one-entry pending register lets the producer queue one byte while another is in flight. A watchdog flags a missing acknowledge.

---
 rtl/toggle_handshake_sender.sv | 165 ++++++++++++++++
 tb/tb_toggle_handshake_sender.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_handshake_sender.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// toggle_handshake_sender
//
// Source side of a toggle-flag clock-domain crossing. Each accepted byte is
// placed on xfer_data and announced by inverting req_toggle. The far domain
// answers by making ack_toggle equal to req_toggle once it has captured the
// byte. One pending entry lets the producer queue a byte while another is in
// flight. A watchdog raises a sticky flag when an acknowledge is late, but
// never aborts the transfer, so toggle parity is never lost.
//
// Ports:
//   clk, rst_n      single clock, asynchronous active-low reset
//   in_data/valid   byte offered by the producer
//   in_ready        block can accept a byte this cycle
//   xfer_data       byte presented to the far domain, stable while in flight
//   req_toggle      inverts once per launched transfer (registered)
//   ack_toggle      asynchronous acknowledge from the far domain
//   busy            transfer in flight or pending entry occupied
//   timeout_err     sticky watchdog flag
//   err_clr         clears timeout_err (a coincident set wins)
// ---------------------------------------------------------------------------
module toggle_handshake_sender #(
    parameter int DATA_W         = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] xfer_data,
    output logic              req_toggle,
    input  logic              ack_toggle,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_e;

    // A zero timeout still needs a legal one-bit counter; the watchdog logic
    // itself is switched off below.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   xfer_q, xfer_d;
    logic                pend_full_q, pend_full_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic                err_q, err_d;

    logic                ack_s;
    logic                accept;
    logic                done;
    logic                launch;
    logic [DATA_W-1:0]   launch_data;
    logic                wd_set;

    // ack_toggle is only ever observed through this synchronizer.
    assign ack_s  = ack_sync_q[SYNC_STAGES-1];
    assign accept = in_valid && !pend_full_q;
    assign done   = (ack_s == req_q);

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        launch      = 1'b0;
        launch_data = in_data;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    launch = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (done) begin
                    if (pend_full_q) begin
                        // in_ready is low here, so nothing new is accepted.
                        launch      = 1'b1;
                        launch_data = pend_data_q;
                        pend_full_d = 1'b0;
                    end else if (accept) begin
                        // Bypass the pending entry when it is empty.
                        launch = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    pend_full_d = 1'b1;
                    pend_data_d = in_data;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d = WAIT_ACK;
        end
        req_d  = req_q ^ launch;
        xfer_d = launch ? launch_data : xfer_q;

        // Watchdog: restarts on every launch, saturates at the limit and
        // produces a single set pulse on the cycle the limit is reached.
        wd_cnt_d = wd_cnt_q;
        wd_set   = 1'b0;
        if (launch) begin
            wd_cnt_d = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (state_q == WAIT_ACK) && (wd_cnt_q != CNT_MAX)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            wd_set   = (wd_cnt_q == CNT_LAST);
        end

        if (wd_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ack_sync_q  <= '0;
            req_q       <= 1'b0;
            xfer_q      <= '0;
            pend_full_q <= 1'b0;
            pend_data_q <= '0;
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], ack_toggle};
            req_q       <= req_d;
            xfer_q      <= xfer_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
        end
    end

    assign in_ready    = !pend_full_q;
    assign busy        = (state_q == WAIT_ACK) || pend_full_q;
    assign xfer_data   = xfer_q;
    assign req_toggle  = req_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_toggle_handshake_sender.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_toggle_handshake_sender
//
// Directed vectors push the bytes they expect to see launched into a queue.
// A monitor on the falling edge pops one entry per req_toggle flip and
// compares xfer_data, and also checks xfer_data is held between flips.
// A far-end model can answer requests after a random delay.
// ---------------------------------------------------------------------------
module tb_toggle_handshake_sender;

    localparam int DATA_W     = 8;
    localparam int TMO        = 15;
    localparam int NUM_RANDOM = 1500;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] xfer_data;
    logic              req_toggle;
    logic              ack_toggle;
    logic              busy;
    logic              timeout_err;
    logic              err_clr;

    // Second instance with the watchdog disabled, sharing all inputs.
    logic              nw_in_ready;
    logic [DATA_W-1:0] nw_xfer_data;
    logic              nw_req_toggle;
    logic              nw_busy;
    logic              nw_timeout_err;

    logic ack_man  = 1'b0;
    logic ack_auto = 1'b0;
    logic auto_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int flips  = 0;
    logic [DATA_W-1:0] exp_q[$];

    logic              mon_prev_req  = 1'b0;
    logic [DATA_W-1:0] mon_prev_data = '0;

    always #5 clk = ~clk;

    assign ack_toggle = auto_ack ? ack_auto : ack_man;

    toggle_handshake_sender #(
        .DATA_W(DATA_W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .xfer_data(xfer_data), .req_toggle(req_toggle),
        .ack_toggle(ack_toggle), .busy(busy), .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    toggle_handshake_sender #(
        .DATA_W(DATA_W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(0)
    ) u_dut_nowd (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(nw_in_ready), .xfer_data(nw_xfer_data), .req_toggle(nw_req_toggle),
        .ack_toggle(ack_toggle), .busy(nw_busy), .timeout_err(nw_timeout_err),
        .err_clr(err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_req(input logic val, input string name);
        int n;
        n = 0;
        while (req_toggle !== val && n < 20) begin
            tick();
            n++;
        end
        check(name, req_toggle, val);
    endtask

    task automatic send_random_byte();
        int n;
        int gap;
        bit acc;
        gap = $urandom_range(0, 3);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = DATA_W'($urandom);
        in_valid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            acc = in_ready;
            if (acc) exp_q.push_back(in_data);
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("random_accept", in_ready, 1'b1);
    endtask

    // Scoreboard monitor.
    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_req  = 1'b0;
                mon_prev_data = '0;
            end else begin
                if (req_toggle != mon_prev_req) begin
                    flips++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL launch_unexpected actual=0x%0h required=none", xfer_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("launch_data", xfer_data, e);
                    end
                end else begin
                    check("xfer_hold", xfer_data, mon_prev_data);
                end
                mon_prev_req  = req_toggle;
                mon_prev_data = xfer_data;
            end
        end
    end

    // Far-end model: in auto mode, acknowledges each request after 1..40 cycles.
    initial begin
        int d;
        forever begin
            @(posedge clk);
            #2;
            if (!auto_ack) begin
                ack_auto = ack_man;
            end else if (req_toggle != ack_auto) begin
                d = $urandom_range(1, 40);
                repeat (d - 1) @(posedge clk);
                #2 ack_auto = req_toggle;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int flips0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        err_clr  = 1'b0;
        tick();
        tick();
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_req", req_toggle, 1'b0);
        check("reset_xfer", xfer_data, 8'h00);
        check("reset_err", timeout_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single transfer and completion latency.
        in_valid = 1'b1;
        in_data  = 8'h90;
        exp_q.push_back(8'h90);
        tick();
        in_valid = 1'b0;
        check("t1_req", req_toggle, 1'b1);
        check("t1_xfer", xfer_data, 8'h90);
        check("t1_busy", busy, 1'b1);
        ack_man = 1'b1;
        tick();
        tick();
        check("t1_busy_during_sync", busy, 1'b1);
        tick();
        check("t1_busy_after_ack", busy, 1'b0);

        // Back-to-back bytes with ack held off.
        flips0   = flips;
        in_valid = 1'b1;
        in_data  = 8'h90;
        exp_q.push_back(8'h90);
        tick();
        in_data = 8'h3C;
        exp_q.push_back(8'h3C);
        tick();
        in_data = 8'h7F;
        check("t2_in_ready_pending", in_ready, 1'b0);
        check("t2_busy", busy, 1'b1);
        check("t2_xfer_first", xfer_data, 8'h90);
        repeat (3) tick();
        check("t2_in_ready_stall", in_ready, 1'b0);
        check("t2_req_held", req_toggle, 1'b0);
        ack_man = 1'b0;
        wait_req(1'b1, "t2_second_launch");
        check("t2_xfer_second", xfer_data, 8'h3C);
        check("t2_in_ready_freed", in_ready, 1'b1);
        exp_q.push_back(8'h7F);
        tick();
        in_valid = 1'b0;
        check("t2_in_ready_third_pending", in_ready, 1'b0);
        ack_man = 1'b1;
        wait_req(1'b0, "t2_third_launch");
        check("t2_xfer_third", xfer_data, 8'h7F);
        ack_man = 1'b0;
        wait_idle("t2_idle");
        check("t2_flip_count", flips - flips0, 3);

        // Ack match and new accept on the same edge, pending empty.
        in_valid = 1'b1;
        in_data  = 8'h11;
        exp_q.push_back(8'h11);
        tick();
        in_valid = 1'b0;
        ack_man  = 1'b1;
        tick();
        tick();
        check("t3_busy_before", busy, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h45;
        exp_q.push_back(8'h45);
        tick();
        in_valid = 1'b0;
        check("t3_req", req_toggle, 1'b0);
        check("t3_xfer", xfer_data, 8'h45);
        check("t3_in_ready", in_ready, 1'b1);
        check("t3_busy", busy, 1'b1);
        ack_man = 1'b0;
        wait_idle("t3_idle");

        // Watchdog.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        exp_q.push_back(8'h5A);
        tick();
        in_valid = 1'b0;
        repeat (TMO - 1) tick();
        check("t4_err_before_limit", timeout_err, 1'b0);
        tick();
        check("t4_err_at_limit", timeout_err, 1'b1);
        check("t4_xfer_kept", xfer_data, 8'h5A);
        check("t4_req_kept", req_toggle, 1'b1);
        check("t4_nowd_err", nw_timeout_err, 1'b0);
        repeat (5) tick();
        check("t4_still_busy", busy, 1'b1);
        ack_man = 1'b1;
        wait_idle("t4_late_ack_idle");
        check("t4_err_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_cleared", timeout_err, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h6B;
        exp_q.push_back(8'h6B);
        tick();
        in_valid = 1'b0;
        repeat (TMO - 1) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_set_beats_clear", timeout_err, 1'b1);
        ack_man = 1'b0;
        wait_idle("t4_second_idle");
        check("t4_nowd_err_end", nw_timeout_err, 1'b0);

        // Reset while a transfer is in flight with the pending entry full.
        in_valid = 1'b1;
        in_data  = 8'h21;
        exp_q.push_back(8'h21);
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        check("t5_pending_full", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_req", req_toggle, 1'b0);
        check("t5_rst_xfer", xfer_data, 8'h00);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_in_ready", in_ready, 1'b1);
        check("t5_rst_err", timeout_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h12;
        exp_q.push_back(8'h12);
        tick();
        in_valid = 1'b0;
        check("t5_fresh_req", req_toggle, 1'b1);
        check("t5_fresh_xfer", xfer_data, 8'h12);
        ack_man = 1'b1;
        wait_idle("t5_idle");

        // Random traffic against the far-end model.
        auto_ack = 1'b1;
        for (int i = 0; i < NUM_RANDOM; i++) begin
            send_random_byte();
        end
        wait_idle("t6_idle");
        tick();
        check("t6_scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
